// File: rtl/matrix_bank_if.sv
// ---------------------------------------------------------------------------
// matrix_bank_if
//   Request/response bundle between the controller and the banked matrix
//   store.
//   Request channel (valid/ready):
//     req_valid  master -> slave  request present
//     req_ready  slave  -> master store can take a request this cycle
//     req_op     master -> slave  0 READ, 1 WRITE, 2 ACC, 3 NOP
//     req_row    master -> slave  row index
//     req_col    master -> slave  column index
//     req_data   master -> slave  WRITE data / ACC addend
//   Response channel (no backpressure):
//     rsp_valid  slave  -> master single-cycle response strobe
//     rsp_data   slave  -> master READ data or new ACC value
//     rsp_ovf    slave  -> master ACC overflowed (saturated or wrapped)
// ---------------------------------------------------------------------------
interface matrix_bank_if #(
    parameter int DATA_W = 32,
    parameter int ROW_W  = 10,
    parameter int COL_W  = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ROW_W-1:0]  req_row;
    logic [COL_W-1:0]  req_col;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_ovf;

    modport master (
        output req_valid, req_op, req_row, req_col, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_ovf
    );

    modport slave (
        input  req_valid, req_op, req_row, req_col, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_ovf
    );
endinterface

// File: rtl/matrix_bank_dp.sv
// ---------------------------------------------------------------------------
// matrix_bank_dp
//   Banked matrix store for the MACC datapath. Rows interleave across
//   NUM_BANKS synchronous-read RAM banks. One request per cycle: READ
//   (2-cycle latency), WRITE (no response) or ACC (in-place add, occupies
//   the store for two cycles and responds with the new stored value).
//   Ports:
//     clk  in   rising-edge clock for all logic
//     rst  in   synchronous reset, active-high (RAM contents are kept)
//     bus  slave side of matrix_bank_if (request + response channels)
// ---------------------------------------------------------------------------
module matrix_bank_dp #(
    parameter int DATA_W    = 32,
    parameter int ROWS      = 1024,
    parameter int COLS      = 1024,
    parameter int NUM_BANKS = 16,
    parameter bit ACC_SAT   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    matrix_bank_if.slave bus
);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int COL_W  = $clog2(COLS);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ADDR_W = ROW_W - BANK_W + COL_W;
    localparam int DEPTH  = ROWS * COLS / NUM_BANKS;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_ACC   = 2'd2;

    typedef enum logic {IDLE, ACC_WR} state_t;

    state_t state_reg, state_next;

    logic              accept;
    logic [BANK_W-1:0] req_bank;
    logic [ADDR_W-1:0] req_addr;

    // Bank/address/addend of the last accepted request. The bank also steers
    // the read-data mux one cycle later, for READ and ACC alike.
    logic [BANK_W-1:0] hold_bank_reg;
    logic [ADDR_W-1:0] hold_addr_reg;
    logic [DATA_W-1:0] hold_data_reg;
    logic              rd_pend_reg;

    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic              rsp_ovf_reg;

    logic [NUM_BANKS-1:0][DATA_W-1:0] bank_rdata;
    logic [ADDR_W-1:0] bank_addr;
    logic [DATA_W-1:0] bank_wdata;

    logic [DATA_W-1:0] old_val;
    logic [DATA_W:0]   sum_ext;
    logic              acc_ovf;
    logic [DATA_W-1:0] acc_result;
    logic              acc_commit;

    assign bus.req_ready = (state_reg == IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign req_bank      = bus.req_row[BANK_W-1:0];
    assign req_addr      = {bus.req_row[ROW_W-1:BANK_W], bus.req_col};

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && bus.req_op == OP_ACC) state_next = ACC_WR;
            ACC_WR:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- ACC arithmetic ----------------
    // The old value comes out of the bank read issued when the ACC was
    // accepted; the sum is formed one bit wider so the sign logic is exact.
    assign old_val = bank_rdata[hold_bank_reg];
    assign sum_ext = {old_val[DATA_W-1], old_val} + {hold_data_reg[DATA_W-1], hold_data_reg};
    assign acc_ovf = (old_val[DATA_W-1] == hold_data_reg[DATA_W-1]) &&
                     (sum_ext[DATA_W-1] != old_val[DATA_W-1]);

    always_comb begin
        acc_result = sum_ext[DATA_W-1:0];
        if (ACC_SAT && acc_ovf) begin
            // Both operands share a sign, so it picks the clamp direction.
            acc_result = old_val[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                           : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    // Reset during ACC_WR drops the write-back as well as the response.
    assign acc_commit = (state_reg == ACC_WR) && !rst;

    // ACC_WR never overlaps an accepted request, so the banks can share a
    // single address/data path.
    assign bank_addr  = (state_reg == ACC_WR) ? hold_addr_reg : req_addr;
    assign bank_wdata = (state_reg == ACC_WR) ? acc_result : bus.req_data;

    // ---------------- RAM banks ----------------
    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [DATA_W-1:0] mem [DEPTH];
            logic [DATA_W-1:0] rd_reg;
            logic              rd_en;
            logic              wr_en;

            assign rd_en = accept && (req_bank == BANK_W'(gi)) &&
                           (bus.req_op == OP_READ || bus.req_op == OP_ACC);
            assign wr_en = (accept && (req_bank == BANK_W'(gi)) && bus.req_op == OP_WRITE) ||
                           (acc_commit && (hold_bank_reg == BANK_W'(gi)));

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem[bank_addr] <= bank_wdata;
                end
                if (rd_en) begin
                    rd_reg <= mem[bank_addr];
                end
            end

            assign bank_rdata[gi] = rd_reg;
        end
    endgenerate

    // ---------------- request hold / response ----------------
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_bank_reg <= req_bank;
            hold_addr_reg <= req_addr;
            hold_data_reg <= bus.req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_reg   <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_ovf_reg   <= 1'b0;
        end else begin
            rd_pend_reg <= accept && (bus.req_op == OP_READ);
            if (state_reg == ACC_WR) begin
                rsp_valid_reg <= 1'b1;
                rsp_data_reg  <= acc_result;
                rsp_ovf_reg   <= acc_ovf;
            end else if (rd_pend_reg) begin
                rsp_valid_reg <= 1'b1;
                rsp_data_reg  <= bank_rdata[hold_bank_reg];
                rsp_ovf_reg   <= 1'b0;
            end else begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_ovf   = rsp_ovf_reg;

endmodule

// File: tb/tb_matrix_bank_dp.sv
// ---------------------------------------------------------------------------
// tb_matrix_bank_dp
//   Drives a saturating and a wrapping instance of matrix_bank_dp with the
//   same request stream. Expected responses (data/ovf for each instance and
//   the cycle they are due in) are queued when a request is issued and
//   popped when that cycle arrives.
// ---------------------------------------------------------------------------
module tb_matrix_bank_dp;
    localparam int DATA_W    = 32;
    localparam int ROWS      = 64;
    localparam int COLS      = 32;
    localparam int NUM_BANKS = 16;
    localparam int ROW_W     = $clog2(ROWS);
    localparam int COL_W     = $clog2(COLS);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_ACC   = 2'd2;
    localparam logic [1:0] OP_NOP   = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matrix_bank_if #(.DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W)) bus_s ();
    matrix_bank_if #(.DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W)) bus_w ();

    matrix_bank_dp #(
        .DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .NUM_BANKS(NUM_BANKS), .ACC_SAT(1'b1)
    ) dut_sat (
        .clk(clk), .rst(rst), .bus(bus_s)
    );

    matrix_bank_dp #(
        .DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .NUM_BANKS(NUM_BANKS), .ACC_SAT(1'b0)
    ) dut_wrap (
        .clk(clk), .rst(rst), .bus(bus_w)
    );

    typedef struct {
        logic [31:0] data_s;
        logic        ovf_s;
        logic [31:0] data_w;
        logic        ovf_w;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_s[int];
    logic [31:0] model_w[int];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference ACC: exact 64-bit sum, then clamp or truncate.
    task automatic acc_ref(input logic [31:0] old_v, input logic [31:0] add_v, input bit sat,
                           output logic [31:0] res, output logic ovf);
        longint s;
        longint max_v;
        longint min_v;
        max_v = 64'sd2147483647;
        min_v = -64'sd2147483648;
        s = longint'($signed(old_v)) + longint'($signed(add_v));
        ovf = (s > max_v) || (s < min_v);
        if (ovf && sat) res = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        else            res = s[31:0];
    endtask

    task automatic check_rsp();
        exp_t e;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            chk("rsp_valid_sat",  {31'b0, bus_s.rsp_valid}, 32'd1);
            chk("rsp_valid_wrap", {31'b0, bus_w.rsp_valid}, 32'd1);
            chk("rsp_data_sat",   bus_s.rsp_data, e.data_s);
            chk("rsp_ovf_sat",    {31'b0, bus_s.rsp_ovf}, {31'b0, e.ovf_s});
            chk("rsp_data_wrap",  bus_w.rsp_data, e.data_w);
            chk("rsp_ovf_wrap",   {31'b0, bus_w.rsp_ovf}, {31'b0, e.ovf_w});
            $display("cycle %0d rsp sat=0x%08h/%0b wrap=0x%08h/%0b", cyc,
                     bus_s.rsp_data, bus_s.rsp_ovf, bus_w.rsp_data, bus_w.rsp_ovf);
        end else if (bus_s.rsp_valid !== 1'b0 || bus_w.rsp_valid !== 1'b0) begin
            chk("unexpected_rsp", {30'b0, bus_s.rsp_valid, bus_w.rsp_valid}, 32'd0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_rsp();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [1:0] op, input int row, input int col,
                         input logic [31:0] data, input bit track);
        int   guard;
        int   key;
        exp_t e;
        guard = 0;
        key   = row * COLS + col;
        while (bus_s.req_ready !== 1'b1 && guard < 8) begin
            tick();
            guard++;
        end
        chk("ready_wait", {31'b0, bus_s.req_ready}, 32'd1);
        bus_s.req_valid = 1'b1;           bus_w.req_valid = 1'b1;
        bus_s.req_op    = op;             bus_w.req_op    = op;
        bus_s.req_row   = ROW_W'(row);    bus_w.req_row   = ROW_W'(row);
        bus_s.req_col   = COL_W'(col);    bus_w.req_col   = COL_W'(col);
        bus_s.req_data  = data;           bus_w.req_data  = data;
        $display("cycle %0d req op=%0d row=%0d col=%0d data=0x%08h", cyc, op, row, col, data);
        if (track) begin
            e.due = cyc + 2;
            case (op)
                OP_READ: begin
                    e.data_s = model_s[key]; e.ovf_s = 1'b0;
                    e.data_w = model_w[key]; e.ovf_w = 1'b0;
                    sb_q.push_back(e);
                end
                OP_WRITE: begin
                    model_s[key] = data;
                    model_w[key] = data;
                end
                OP_ACC: begin
                    acc_ref(model_s[key], data, 1'b1, e.data_s, e.ovf_s);
                    acc_ref(model_w[key], data, 1'b0, e.data_w, e.ovf_w);
                    model_s[key] = e.data_s;
                    model_w[key] = e.data_w;
                    sb_q.push_back(e);
                end
                default: ;
            endcase
        end
        tick();
        bus_s.req_valid = 1'b0;
        bus_w.req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() > 0 && guard < 12) begin
            tick();
            guard++;
        end
        chk("drain", sb_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        bus_s.req_valid = 1'b0; bus_w.req_valid = 1'b0;
        bus_s.req_op = 2'd0;    bus_w.req_op = 2'd0;
        bus_s.req_row = '0;     bus_w.req_row = '0;
        bus_s.req_col = '0;     bus_w.req_col = '0;
        bus_s.req_data = '0;    bus_w.req_data = '0;

        // Reset held for three cycles
        rst = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_rsp_valid", {31'b0, bus_s.rsp_valid}, 32'd0);
            chk("rst_req_ready", {31'b0, bus_s.req_ready}, 32'd0);
        end
        chk("rst_rsp_data", bus_s.rsp_data, 32'd0);
        chk("rst_rsp_ovf",  {31'b0, bus_w.rsp_ovf}, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'b0, bus_s.req_ready}, 32'd1);

        // WRITE then READ of the same cell on the next cycle
        issue(OP_WRITE, 5, 7, 32'h1234_5678, 1'b1);
        issue(OP_READ,  5, 7, 32'h0, 1'b1);
        drain();

        // Bank sweep: back-to-back writes, then back-to-back reads
        for (int r = 0; r < 32; r++) issue(OP_WRITE, r, r, 32'(r + 1), 1'b1);
        for (int r = 0; r < 32; r++) issue(OP_READ,  r, r, 32'h0, 1'b1);
        drain();

        // Back-to-back ACC, then READ
        issue(OP_WRITE, 10, 4, 32'd10, 1'b1);
        issue(OP_ACC,   10, 4, 32'd5, 1'b1);
        chk("acc1_ready_low", {31'b0, bus_s.req_ready}, 32'd0);
        issue(OP_ACC,   10, 4, 32'hFFFF_FFEC, 1'b1);
        chk("acc2_ready_low", {31'b0, bus_s.req_ready}, 32'd0);
        issue(OP_READ,  10, 4, 32'h0, 1'b1);
        drain();

        // Positive and negative overflow, with read-back of the stored value
        issue(OP_WRITE, 20, 3, 32'h7FFF_FFF0, 1'b1);
        issue(OP_ACC,   20, 3, 32'h0000_0100, 1'b1);
        issue(OP_READ,  20, 3, 32'h0, 1'b1);
        issue(OP_WRITE, 21, 6, 32'h8000_0010, 1'b1);
        issue(OP_ACC,   21, 6, 32'hFFFF_FF00, 1'b1);
        issue(OP_READ,  21, 6, 32'h0, 1'b1);
        drain();

        // Reserved op: accepted, no RAM change, no response
        issue(OP_WRITE, 7, 1, 32'hA5A5_A5A5, 1'b1);
        issue(OP_NOP,   7, 1, 32'hDEAD_BEEF, 1'b0);
        issue(OP_READ,  7, 1, 32'h0, 1'b1);
        drain();

        // Reset in the ACC_WR cycle drops write-back and response
        issue(OP_WRITE, 9, 2, 32'd3, 1'b1);
        issue(OP_ACC,   9, 2, 32'd4, 1'b0);
        rst = 1'b1;
        #1;
        chk("accwr_rst_ready", {31'b0, bus_s.req_ready}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        issue(OP_READ, 9, 2, 32'h0, 1'b1);
        drain();

        // Reset while a READ is in flight suppresses its response
        issue(OP_READ, 5, 7, 32'h0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        issue(OP_READ, 5, 7, 32'h0, 1'b1);
        drain();

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
